qmult_seq: RTL

- Sequential signed-magnitude fixed-point multiplier. It is the multiply-direction counterpart to the team's sequential divider, qdiv.
- Uses the same Q-format as qadd, qmult and qdiv: MSB is the sign, the low Q bits are fraction, and the remaining bits are integer.
- Handshake is start/done, matching qdiv, so either block can sit behind the same arithmetic wrapper.
- Trades latency for area: one shift-add step per cycle.

---
 rtl/qfmt_pkg.sv | 19 +
 rtl/qmag_sat.sv | 26 ++
 rtl/qmult_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/qfmt_pkg.sv
// Shared Q-format definitions for the qadd / qmult / qdiv family.
package qfmt_pkg;

    // Sequencer states shared by the multi-cycle arithmetic blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } qstate_e;

    localparam int Q_DEF = 23;
    localparam int N_DEF = 32;

    // Index of the sign bit in an n-bit sign-magnitude word.
    function automatic int sign_idx(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/qmag_sat.sv
// Product formatter: truncation, saturation on overflow, no negative zero.
module qmag_sat
    import qfmt_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic [2*N-3:0] p,
    input  logic           sign,
    output logic [N-1:0]   c,
    output logic           ovr
);

    localparam int M = N - 1;

    logic [M-1:0] mag;

    // Any integer bit above the representable range flags overflow and
    // saturates; fraction bits below Q are simply dropped.
    always_comb begin
        ovr = |p[2*N-3:Q+N-1];
        mag = ovr ? {M{1'b1}} : p[Q+N-2:Q];
        c   = {sign & (|mag), mag};
    end

endmodule

// File: rtl/qmult_seq.sv
// Sequential sign-magnitude Q-format multiplier, one shift-add step per cycle.
module qmult_seq
    import qfmt_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         start,
    output logic [N-1:0] c,
    output logic         busy,
    output logic         done,
    output logic         ovr
);

    localparam int M  = N - 1;        // magnitude width
    localparam int PW = 2 * N - 2;    // full product width
    localparam int CW = $clog2(N);    // holds N-1
    localparam int SB = sign_idx(N);

    qstate_e        state_q, state_d;
    logic [PW-1:0]  mcand_q, mcand_d;
    logic [M-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic           sign_q, sign_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   c_q, c_d;
    logic           ovr_q, ovr_d;
    logic           done_q, done_d;

    logic [N-1:0]   sat_c;
    logic           sat_ovr;

    qmag_sat #(.Q(Q), .N(N)) u_sat (
        .p    (acc_q),
        .sign (sign_q),
        .c    (sat_c),
        .ovr  (sat_ovr)
    );

    // Next-state and datapath: latch in IDLE, shift-add in RUN, publish in DONE.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        ovr_d    = ovr_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{(PW-M){1'b0}}, a[M-1:0]};
                    mplier_d = b[M-1:0];
                    sign_d   = a[SB] ^ b[SB];
                    acc_d    = '0;
                    cnt_d    = CW'(M);
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q - 1'b1;
                // The last of the N-1 steps happens on this edge.
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                c_d     = sat_c;
                ovr_d   = sat_ovr;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            c_q      <= '0;
            ovr_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            ovr_q    <= ovr_d;
            done_q   <= done_d;
        end
    end

    assign c    = c_q;
    assign ovr  = ovr_q;
    assign done = done_q;
    assign busy = (state_q == RUN);

endmodule
